// File: rtl/param_funnel_shifter.sv
// param_funnel_shifter: a two-stage pipelined funnel/rotate shifter with
// valid/ready handshakes on both sides.
// Stage 1 captures the operands, the mode and the effective shift amount.
// Stage 2 captures the extracted W-bit window and the clamp flag.
// One log-stage barrel shifter serves all four modes:
//   - Right-hand modes shift the bit-reversed concatenation left.
//   - Rotate modes use {hi,hi} as the concatenation.
module param_funnel_shifter #(
    parameter int W = 10,
    localparam int AW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  hi,
    input  logic [W-1:0]  lo,
    input  logic [AW-1:0] amt,
    input  logic [1:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  y,
    output logic          ovf
);

    // W always fits in AW bits because 2**AW >= W+1.
    localparam logic [AW-1:0] W_AMT = AW'(W);

    // Funnel modes saturate the amount at W: the window is then entirely one operand.
    function automatic logic [AW-1:0] clamp_amt(input logic [AW-1:0] a);
        return (a > W_AMT) ? W_AMT : a;
    endfunction

    // Rotate modes reduce the amount modulo W.
    // Since 2**(AW-1) <= W, any AW-bit value is below 2W, so one subtract suffices.
    function automatic logic [AW-1:0] wrap_amt(input logic [AW-1:0] a);
        return (a >= W_AMT) ? (a - W_AMT) : a;
    endfunction

    function automatic logic [2*W-1:0] reverse_2w(input logic [2*W-1:0] v);
        logic [2*W-1:0] r;
        for (int k = 0; k < 2 * W; k++) begin
            r[k] = v[2*W-1-k];
        end
        return r;
    endfunction

    // Upper-half window of (c << e), or lower-half window of (c >> e) when right=1.
    // A right shift is done as: reverse, shift left, take upper half, reverse back.
    function automatic logic [W-1:0] window_shift(input logic [2*W-1:0] c,
                                                  input logic [AW-1:0]  e,
                                                  input logic           right);
        logic [2*W-1:0] s;
        logic [W-1:0]   upper;
        logic [W-1:0]   r;
        s = right ? reverse_2w(c) : c;
        for (int k = 0; k < AW; k++) begin
            if (e[k]) begin
                s = s << (1 << k);
            end
        end
        upper = s[2*W-1:W];
        for (int k = 0; k < W; k++) begin
            r[k] = right ? upper[W-1-k] : upper[k];
        end
        return r;
    endfunction

    logic          adv1;
    logic          adv2;

    logic [AW-1:0] eamt_in;
    logic          ovf_in;

    logic          vld_p1_q, vld_p1_d;
    logic [W-1:0]  hi_p1_q, hi_p1_d;
    logic [W-1:0]  lo_p1_q, lo_p1_d;
    logic [1:0]    mode_p1_q, mode_p1_d;
    logic [AW-1:0] eamt_p1_q, eamt_p1_d;
    logic          ovf_p1_q, ovf_p1_d;

    logic [W-1:0]  y_calc;

    logic          vld_p2_q, vld_p2_d;
    logic [W-1:0]  y_p2_q, y_p2_d;
    logic          ovf_p2_q, ovf_p2_d;

    // A stage may load when it is empty or when its contents leave on the same edge.
    // in_ready depends only on register state and out_ready.
    assign adv2     = !vld_p2_q || out_ready;
    assign adv1     = !vld_p1_q || adv2;
    assign in_ready = adv1;

    assign out_valid = vld_p2_q;
    assign y         = y_p2_q;
    assign ovf       = ovf_p2_q;

    // Effective shift amount and clamp flag for the incoming request.
    always_comb begin
        eamt_in = wrap_amt(amt);
        ovf_in  = 1'b0;
        if (!mode[1]) begin
            eamt_in = clamp_amt(amt);
            ovf_in  = (amt > W_AMT);
        end
    end

    // Stage 1 next state: load a request on an input transfer, otherwise hold.
    always_comb begin
        vld_p1_d  = vld_p1_q;
        hi_p1_d   = hi_p1_q;
        lo_p1_d   = lo_p1_q;
        mode_p1_d = mode_p1_q;
        eamt_p1_d = eamt_p1_q;
        ovf_p1_d  = ovf_p1_q;
        if (adv1) begin
            vld_p1_d = in_valid;
            if (in_valid) begin
                hi_p1_d   = hi;
                lo_p1_d   = lo;
                mode_p1_d = mode;
                eamt_p1_d = eamt_in;
                ovf_p1_d  = ovf_in;
            end
        end
    end

    // Window extraction between the stages.
    // Rotates substitute hi for lo in the concatenation.
    always_comb begin
        y_calc = window_shift({hi_p1_q, (mode_p1_q[1] ? hi_p1_q : lo_p1_q)},
                              eamt_p1_q, mode_p1_q[0]);
    end

    // Stage 2 next state.
    // Results are captured only when valid, so y and ovf hold during backpressure and bubbles.
    always_comb begin
        vld_p2_d = vld_p2_q;
        y_p2_d   = y_p2_q;
        ovf_p2_d = ovf_p2_q;
        if (adv2) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                y_p2_d   = y_calc;
                ovf_p2_d = ovf_p1_q;
            end
        end
    end

    // Pipeline registers. Reset flushes both stages and clears all data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            hi_p1_q   <= '0;
            lo_p1_q   <= '0;
            mode_p1_q <= '0;
            eamt_p1_q <= '0;
            ovf_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            y_p2_q    <= '0;
            ovf_p2_q  <= 1'b0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            hi_p1_q   <= hi_p1_d;
            lo_p1_q   <= lo_p1_d;
            mode_p1_q <= mode_p1_d;
            eamt_p1_q <= eamt_p1_d;
            ovf_p1_q  <= ovf_p1_d;
            vld_p2_q  <= vld_p2_d;
            y_p2_q    <= y_p2_d;
            ovf_p2_q  <= ovf_p2_d;
        end
    end

endmodule

// File: tb/tb_param_funnel_shifter.sv
// Bench for param_funnel_shifter at W=10: directed vectors, multi-cycle
// corner sequences and a randomized handshake stream against a reference model.
module tb_param_funnel_shifter;

    localparam int W  = 10;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [AW-1:0] amt;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    param_funnel_shifter #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .hi        (hi),
        .lo        (lo),
        .amt       (amt),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0]  hi;
        logic [W-1:0]  lo;
        logic [AW-1:0] amt;
        logic [1:0]    mode;
        logic [W-1:0]  y;
        logic          ovf;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {ovf, y} computed arithmetically from the mode rules.
    function automatic logic [W:0] model(input logic [W-1:0] h, input logic [W-1:0] l,
                                         input logic [AW-1:0] a, input logic [1:0] m);
        int             e;
        logic [2*W-1:0] c;
        logic [2*W-1:0] hx;
        logic [2*W-1:0] t;
        logic           o;
        c  = {h, l};
        hx = {{W{1'b0}}, h};
        o  = 1'b0;
        if (!m[1]) begin
            e = (int'(a) > W) ? W : int'(a);
            o = (int'(a) > W);
            if (!m[0]) begin
                t = c << e;
                return {o, t[2*W-1:W]};
            end
            t = c >> e;
            return {o, t[W-1:0]};
        end
        e = int'(a) % W;
        if (!m[0]) t = (hx << e) | (hx >> (W - e));
        else       t = (hx >> e) | (hx << (W - e));
        return {o, t[W-1:0]};
    endfunction

    logic [W-1:0]  bp_hi[5];
    logic [W-1:0]  bp_lo[5];
    logic [AW-1:0] bp_amt[5];
    logic [1:0]    bp_mode[5];
    logic [W:0]    bp_exp[5];
    logic [W-1:0]  b2b_y[4];
    logic [W:0]    exp_q[$];

    initial begin
        int  idx;
        int  got;
        int  sent;
        int  recv;
        int  cyc;
        logic acc;
        logic held;
        logic [W:0] held_val;
        logic [W:0] e;

        tbl[0] = '{10'h2A5, 10'h3C0, 4'd0,  2'b00, 10'h2A5, 1'b0};
        tbl[1] = '{10'h2A5, 10'h3C0, 4'd10, 2'b00, 10'h3C0, 1'b0};
        tbl[2] = '{10'h2A5, 10'h3C0, 4'd10, 2'b01, 10'h2A5, 1'b0};
        tbl[3] = '{10'h2A5, 10'h3C0, 4'd12, 2'b00, 10'h3C0, 1'b1};
        tbl[4] = '{10'h2A5, 10'h3C0, 4'd15, 2'b01, 10'h2A5, 1'b1};
        tbl[5] = '{10'h2A5, 10'h3C0, 4'd13, 2'b10, 10'h12D, 1'b0};
        tbl[6] = '{10'h2A5, 10'h3C0, 4'd10, 2'b11, 10'h2A5, 1'b0};
        tbl[7] = '{10'h2A5, 10'h3C0, 4'd0,  2'b01, 10'h3C0, 1'b0};
        tbl[8] = '{10'h2A5, 10'h3C0, 4'd3,  2'b11, 10'h2D4, 1'b0};
        b2b_y[0] = 10'h12F;
        b2b_y[1] = 10'h2F8;
        b2b_y[2] = 10'h12D;
        b2b_y[3] = 10'h2D4;

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        hi = '0; lo = '0; amt = '0; mode = '0;
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;
        step();
        chk("rst_in_ready", 32'(in_ready), 1);

        // Four modes back-to-back, amt=3
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c < 4);
            hi = 10'h2A5; lo = 10'h3C0; amt = 4'd3; mode = 2'(c);
            step();
            if (c >= 1) begin
                chk($sformatf("b2b_valid%0d", c - 1), 32'(out_valid), 1);
                chk($sformatf("b2b_y%0d", c - 1), 32'(y), 32'(b2b_y[c-1]));
                chk($sformatf("b2b_ovf%0d", c - 1), 32'(ovf), 0);
            end
        end
        in_valid = 1'b0;
        step();
        chk("b2b_drained", 32'(out_valid), 0);

        // Table of single requests: boundaries, clamp and modulo
        for (int i = 0; i < 9; i++) begin
            hi = tbl[i].hi; lo = tbl[i].lo; amt = tbl[i].amt; mode = tbl[i].mode;
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 1);
            step();
            in_valid = 1'b0;
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("tbl%0d_y", i), 32'(y), 32'(tbl[i].y));
            chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
            step();
            chk($sformatf("tbl%0d_empty", i), 32'(out_valid), 0);
        end

        // Backpressure: 5 requests, consumer stalled for 4 cycles
        for (int i = 0; i < 5; i++) begin
            bp_hi[i] = 10'($urandom); bp_lo[i] = 10'($urandom);
            bp_amt[i] = 4'($urandom_range(0, 15)); bp_mode[i] = 2'($urandom_range(0, 3));
            bp_exp[i] = model(bp_hi[i], bp_lo[i], bp_amt[i], bp_mode[i]);
        end
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            hi = bp_hi[idx]; lo = bp_lo[idx]; amt = bp_amt[idx]; mode = bp_mode[idx];
            #1;
            acc = in_ready;
            step();
            if (acc) idx++;
            if (c >= 1) begin
                chk($sformatf("bp_hold_valid%0d", c), 32'(out_valid), 1);
                chk($sformatf("bp_hold_y%0d", c), 32'({ovf, y}), 32'(bp_exp[0]));
            end
        end
        chk("bp_accepts", 32'(idx), 2);
        chk("bp_in_ready_low", 32'(in_ready), 0);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 5; c++) begin
            in_valid = (idx < 5);
            hi = bp_hi[idx < 5 ? idx : 0]; lo = bp_lo[idx < 5 ? idx : 0];
            amt = bp_amt[idx < 5 ? idx : 0]; mode = bp_mode[idx < 5 ? idx : 0];
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk($sformatf("bp_out%0d", got), 32'({ovf, y}), 32'(bp_exp[got < 5 ? got : 0]));
                got++;
            end
            step();
            if (acc) idx++;
        end
        chk("bp_all_out", 32'(got), 5);
        in_valid = 1'b0;
        step();

        // Randomized handshakes against the model
        sent = 0; recv = 0; cyc = 0; held = 1'b0; held_val = '0;
        while (recv < 1000 && cyc < 20000) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            hi        = 10'($urandom);
            lo        = 10'($urandom);
            amt       = 4'($urandom_range(0, 15));
            mode      = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (held) begin
                chk("rnd_hold_valid", 32'(out_valid), 1);
                chk("rnd_hold_y", 32'({ovf, y}), 32'(held_val));
            end
            held     = out_valid && !out_ready;
            held_val = {ovf, y};
            if (in_valid && in_ready) begin
                exp_q.push_back(model(hi, lo, amt, mode));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_out", 32'(recv), 32'(sent));
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("rnd_out%0d", recv), 32'({ovf, y}), 32'(e));
                end
                recv++;
            end
            step();
            cyc++;
        end
        chk("rnd_received", 32'(recv), 1000);
        chk("rnd_queue_empty", 32'(exp_q.size()), 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // Reset with both stages full
        out_ready = 1'b0;
        hi = 10'h2A5; lo = 10'h3C0; amt = 4'd0; mode = 2'b00;
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        chk("flush_full_in_ready", 32'(in_ready), 0);
        chk("flush_full_valid", 32'(out_valid), 1);
        chk("flush_full_y", 32'(y), 32'h2A5);
        #2;
        rst = 1'b1;
        #1;
        chk("flush_async_valid", 32'(out_valid), 0);
        chk("flush_async_y", 32'(y), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("flush_in_ready", 32'(in_ready), 1);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("flush_no_out%0d", c), 32'(out_valid), 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
